// File: rtl/shift_reg_pipo.sv
// One-cycle parallel-in/parallel-out register stage with capture-valid and word-change flags.
// Optional even-parity output is enabled by defining SHIFT_REG_PIPO_PARITY_EN.
module shift_reg_pipo #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             changed
`ifdef SHIFT_REG_PIPO_PARITY_EN
  ,
  output logic             parity
`endif
);

  // Case inequality keeps X/Z on d visible as a change instead of collapsing it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q       <= RESET_VALUE;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      q       <= d;
      valid   <= 1'b1;
      changed <= (d !== q);
    end
  end

`ifdef SHIFT_REG_PIPO_PARITY_EN
  // Parity is registered alongside q so it always matches ^q, reset included.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity <= ^RESET_VALUE;
    end else begin
      parity <= ^d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_pipo.sv
// Bench for shift_reg_pipo: vector table, hand-written glitch/reset sequences, random loads.
// Expected output words go into a scoreboard queue and are popped just after each edge.
`timescale 1ns/100ps
module tb_shift_reg_pipo;

  localparam int W  = 8;
  localparam int EW = W + 3;
`ifdef SHIFT_REG_PIPO_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         valid;
  logic         changed;
  logic         parity;

  shift_reg_pipo #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .q       (q),
    .valid   (valid),
    .changed (changed)
`ifdef SHIFT_REG_PIPO_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

`ifndef SHIFT_REG_PIPO_PARITY_EN
  assign parity = 1'b0;
`endif

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rn;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         v;
    logic         c;
    logic         p;
  } vec_t;

  vec_t         vecs[10];
  logic [EW-1:0] exp_q[$];
  logic [W-1:0] mq;
  int           vectors;
  int           miscompares;

  // scoreboard
  task automatic push_exp(input logic [W-1:0] eq, input logic ev, input logic ec, input logic ep);
    exp_q.push_back({eq, ev, ec, ep & PAR_EN});
  endtask

  task automatic check(input string name);
    logic [EW-1:0] a;
    logic [EW-1:0] e;
    vectors++;
    a = {q, valid, changed, parity};
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, got q=%h v=%b c=%b p=%b", name, q, valid, changed, parity);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got q=%h v=%b c=%b p=%b, expected q=%h v=%b c=%b p=%b",
                 name, a[EW-1:3], a[2], a[1], a[0], e[EW-1:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic check_hold(input string name, input logic [W-1:0] eq, input logic ev);
    vectors++;
    if (q !== eq || valid !== ev) begin
      miscompares++;
      $display("FAIL %s: got q=%h v=%b, expected q=%h v=%b", name, q, valid, eq, ev);
    end
  endtask

  // driver tasks
  task automatic step(input logic rn, input logic [W-1:0] dv, input logic [W-1:0] eq,
                      input logic ev, input logic ec, input logic ep, input string name);
    reset_n = rn;
    d       = dv;
    push_exp(eq, ev, ec, ep);
    @(posedge clk);
    #0.1;
    check(name);
    mq = eq;
  endtask

  task automatic load(input logic [W-1:0] dv, input string name);
    step(1'b1, dv, dv, 1'b1, (dv !== mq), ^dv, name);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mq          = 8'h00;
    reset_n     = 1'b0;
    d           = 8'hA5;

    vecs[0] = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'hC3, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h07, 8'h07, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'h03, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rn, vecs[i].d, vecs[i].q, vecs[i].v, vecs[i].c, vecs[i].p,
           $sformatf("table_%0d", i));
    end

    // glitch between edges must never reach q
    d = 8'hFF;
    #2;
    check_hold("glitch_hold", 8'h03, 1'b1);
    d = 8'h12;
    push_exp(8'h12, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #0.1;
    check("glitch_load");
    mq = 8'h12;

    // reset dropped mid-cycle only acts at the next edge; d at that edge is discarded
    load(8'h55, "load_55");
    #3;
    reset_n = 1'b0;
    d       = 8'hAA;
    #1;
    check_hold("reset_mid_hold", 8'h55, 1'b1);
    push_exp(8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #0.1;
    check("reset_mid_edge");
    mq = 8'h00;

    // random loads with 0-3 time-unit gaps after each edge
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] rv;
      int           gap;
      rv  = W'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      #(gap);
      load(rv, $sformatf("rand_%0d", i));
    end

    step(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, "final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
